// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the boot-time program loader.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LEN,
        DATA,
        WRITE,
        CHK,
        DONE,
        ERR
    } prog_state_e;

    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned WORD_BYTES = 4;
    localparam logic [3:0]  MEM_BE_ALL = 4'hF;

endpackage

// File: rtl/prog_word_asm.sv
// Little-endian byte-to-word assembler shared by the header, data and trailer phases.
module prog_word_asm
    import prog_loader_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_valid_i,
    input  logic [7:0]  byte_i,
    output logic        word_valid_o,
    output logic [31:0] word_o
);

    localparam int unsigned CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_base;
    logic [31:0]      shreg_q;

    // A byte arriving together with clear is treated as byte 0 of a fresh word.
    assign cnt_base     = clear_i ? '0 : cnt_q;
    assign word_valid_o = byte_valid_i && (cnt_base == CNT_W'(WORD_BYTES - 1));
    assign word_o       = {byte_i, shreg_q[31:8]};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else if (byte_valid_i) begin
            cnt_q   <= cnt_base + 1'b1;
            shreg_q <= word_o;
        end else if (clear_i) begin
            cnt_q   <= '0;
        end
    end

endmodule

// File: rtl/prog_loader.sv
// UART-fed instruction-memory loader; holds the core in reset while a frame is loaded.
// Optional PROG_CHECKSUM_EN adds a 32-bit sum trailer checked after the last word.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 12,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
    parameter int unsigned       TIMEOUT_CYC = 1_000_000
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              prog_en_i,
    input  logic              rx_valid_i,
    input  logic [7:0]        rx_data_i,
    output logic              rx_ready_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    output logic [3:0]        mem_be_o,
    input  logic              mem_gnt_i,
    output logic              prog_rst_no,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o
);

    localparam int unsigned TMO_W     = $clog2(TIMEOUT_CYC + 1);
    localparam logic [32:0] MAX_WORDS = 33'd1 << ADDR_W;
`ifdef PROG_CHECKSUM_EN
    localparam prog_state_e LAST_STATE = CHK;
`else
    localparam prog_state_e LAST_STATE = DONE;
`endif

    prog_state_e      state_q;
    logic [ADDR_W:0]  len_q;
    logic [ADDR_W:0]  wcnt_q;
    logic [TMO_W-1:0] tmo_q;
    logic             accept, start, rx_phase, asm_clear, asm_vld, tmo_hit;
    logic             word_vld;
    logic [31:0]      word;
`ifdef PROG_CHECKSUM_EN
    logic [31:0]      sum_q;
`endif

    assign accept    = rx_valid_i && rx_ready_o;
    assign asm_clear = state_q inside {IDLE, DONE, ERR};
    assign rx_phase  = state_q inside {LEN, DATA, CHK};
    assign start     = accept && prog_en_i && asm_clear;
    assign asm_vld   = start || (accept && rx_phase);
    assign tmo_hit   = rx_phase && !accept && (tmo_q == TMO_W'(TIMEOUT_CYC - 1));
    assign mem_we_o  = mem_req_o;
    assign mem_be_o  = MEM_BE_ALL;

    prog_word_asm u_asm (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .clear_i      (asm_clear),
        .byte_valid_i (asm_vld),
        .byte_i       (rx_data_i),
        .word_valid_o (word_vld),
        .word_o       (word)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            rx_ready_o  <= 1'b1;
            mem_req_o   <= 1'b0;
            mem_addr_o  <= BASE_ADDR;
            mem_wdata_o <= '0;
            prog_rst_no <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            err_o       <= 1'b0;
            len_q       <= '0;
            wcnt_q      <= '0;
            tmo_q       <= '0;
`ifdef PROG_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            // Idle-gap counter; frozen while a write waits for its grant.
            if (accept)        tmo_q <= '0;
            else if (rx_phase) tmo_q <= tmo_q + 1'b1;

            case (state_q)
                IDLE, DONE, ERR: begin
                    if (start) begin
                        state_q     <= LEN;
                        prog_rst_no <= 1'b0;
                        busy_o      <= 1'b1;
                        done_o      <= 1'b0;
                        err_o       <= 1'b0;
                        mem_addr_o  <= BASE_ADDR;
                        wcnt_q      <= '0;
`ifdef PROG_CHECKSUM_EN
                        sum_q       <= '0;
`endif
                    end else if (state_q == DONE || accept) begin
                        state_q     <= IDLE;
                        prog_rst_no <= 1'b1;
                    end
                end
                LEN: if (word_vld) begin
                    len_q <= word[ADDR_W:0];
                    if ({1'b0, word} > MAX_WORDS) begin
                        state_q <= ERR;
                        err_o   <= 1'b1;
                        busy_o  <= 1'b0;
                    end else if (word == '0) begin
                        state_q <= LAST_STATE;
                        if (LAST_STATE == DONE) begin
                            prog_rst_no <= 1'b1;
                            busy_o      <= 1'b0;
                            done_o      <= 1'b1;
                        end
                    end else begin
                        state_q <= DATA;
                    end
                end
                DATA: if (word_vld) begin
                    state_q     <= WRITE;
                    mem_req_o   <= 1'b1;
                    rx_ready_o  <= 1'b0;
                    mem_wdata_o <= word;
                end
                WRITE: if (mem_gnt_i) begin
                    mem_req_o  <= 1'b0;
                    rx_ready_o <= 1'b1;
                    mem_addr_o <= mem_addr_o + 1'b1;
                    wcnt_q     <= wcnt_q + 1'b1;
`ifdef PROG_CHECKSUM_EN
                    sum_q      <= sum_q + mem_wdata_o;
`endif
                    if (wcnt_q + 1'b1 == len_q) begin
                        state_q <= LAST_STATE;
                        if (LAST_STATE == DONE) begin
                            prog_rst_no <= 1'b1;
                            busy_o      <= 1'b0;
                            done_o      <= 1'b1;
                        end
                    end else begin
                        state_q <= DATA;
                    end
                end
`ifdef PROG_CHECKSUM_EN
                CHK: if (word_vld) begin
                    busy_o <= 1'b0;
                    if (word == sum_q) begin
                        state_q     <= DONE;
                        prog_rst_no <= 1'b1;
                        done_o      <= 1'b1;
                    end else begin
                        state_q <= ERR;
                        err_o   <= 1'b1;
                    end
                end
`endif
                default: state_q <= IDLE;
            endcase

            // Mutually exclusive with word_vld, which always comes with an accepted byte.
            if (tmo_hit) begin
                state_q <= ERR;
                err_o   <= 1'b1;
                busy_o  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Randomized self-checking bench for prog_loader with a frame-level reference model.
module tb_prog_loader;

    localparam int ADDR_W = 4;
    localparam int BASE   = 2;
    localparam int TMO    = 40;
    localparam int MAXW   = 1 << ADDR_W;
`ifdef PROG_CHECKSUM_EN
    localparam bit CK_EN = 1'b1;
`else
    localparam bit CK_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              prog_en = 1'b1;
    logic              rx_valid = 1'b0;
    logic [7:0]        rx_data = 8'h0;
    logic              rx_ready;
    logic              mem_req, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_be;
    logic              mem_gnt = 1'b0;
    logic              prog_rst_n, busy, done, err;

    int          n_chk = 0;
    int          n_pass = 0;
    int          gnt_delay = 0;
    int          gnt_wait = 0;
    int          gap_max = 2;
    bit          stall_prev = 1'b0;
    logic [63:0] stall_val;
    logic [63:0] wr_q[$];
    logic [31:0] words[$];

    always #5 clk = ~clk;

    prog_loader #(
        .ADDR_W      (ADDR_W),
        .BASE_ADDR   (ADDR_W'(BASE)),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .prog_en_i   (prog_en),
        .rx_valid_i  (rx_valid),
        .rx_data_i   (rx_data),
        .rx_ready_o  (rx_ready),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_be_o    (mem_be),
        .mem_gnt_i   (mem_gnt),
        .prog_rst_no (prog_rst_n),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Memory side: grants after gnt_delay waiting cycles, logs each completed write.
    always @(negedge clk) begin
        if (mem_req) begin
            chk("ready_in_write", 64'(rx_ready), 64'd0);
            chk("we_be", 64'({mem_we, mem_be}), 64'h1F);
            if (stall_prev) chk("req_stable", 64'({mem_addr, mem_wdata}), stall_val);
            stall_val  = 64'({mem_addr, mem_wdata});
            stall_prev = 1'b1;
            if (gnt_wait >= gnt_delay) begin
                mem_gnt = 1'b1;
                wr_q.push_back(64'({mem_addr, mem_wdata}));
            end else begin
                gnt_wait++;
            end
        end else begin
            mem_gnt    = 1'b0;
            gnt_wait   = 0;
            stall_prev = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        rx_valid = 1'b1;
        rx_data  = b;
        while (!rx_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) chk("rx_ready_wait", 64'(rx_ready), 64'd1);
        @(negedge clk);
        rx_valid = 1'b0;
        repeat ($urandom_range(0, gap_max)) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    function automatic logic [31:0] wsum();
        logic [31:0] s = 32'h0;
        foreach (words[i]) s += words[i];
        return s;
    endfunction

    task automatic finish_frame(input string tag, input int nwr, input bit ok);
        int t = 0;
        logic [ADDR_W-1:0] a;
        while (!(done || err) && t < 300) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_end_seen"}, 64'(done || err), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'(ok));
        chk({tag, "_err"}, 64'(err), 64'(!ok));
        chk({tag, "_prog_rst"}, 64'(prog_rst_n), 64'(ok));
        chk({tag, "_busy"}, 64'(busy), 64'd0);
        chk({tag, "_nwr"}, 64'(wr_q.size()), 64'(nwr));
        for (int i = 0; i < nwr && i < wr_q.size(); i++) begin
            a = ADDR_W'(BASE + i);
            chk({tag, "_wr"}, wr_q[i], 64'({a, words[i]}));
        end
        wr_q.delete();
    endtask

    // Reference: a frame is accepted iff N fits memory and (if enabled) the trailer equals the sum.
    task automatic frame(input string tag, input logic [31:0] n, input logic [31:0] trailer,
                         input bit drop_en);
        bit ok;
        int nwr = 0;
        send_byte(n[7:0]);
        chk({tag, "_start_rst"}, 64'(prog_rst_n), 64'd0);
        chk({tag, "_start_flags"}, 64'({busy, done, err}), 64'b100);
        if (drop_en) prog_en = 1'b0;
        send_byte(n[15:8]);
        send_byte(n[23:16]);
        send_byte(n[31:24]);
        ok = (n <= 32'(MAXW));
        if (ok) begin
            foreach (words[i]) send_word(words[i]);
            nwr = words.size();
            if (CK_EN) begin
                send_word(trailer);
                ok = (trailer == wsum());
            end
        end
        finish_frame(tag, nwr, ok);
        prog_en = 1'b1;
    endtask

    task automatic rand_words(input int n);
        words.delete();
        for (int i = 0; i < n; i++) words.push_back($urandom());
    endtask

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_outs", 64'({prog_rst_n, rx_ready, mem_req, busy, done, err}), 64'b110000);
        chk("rst_addr", 64'(mem_addr), 64'(BASE));
        rst_n = 1'b1;
        @(negedge clk);

        // Loader disabled: bytes are swallowed, nothing starts.
        prog_en = 1'b0;
        send_word(32'h1);
        send_word(32'hCAFE_F00D);
        chk("dis_state", 64'({prog_rst_n, busy, done, err}), 64'b1000);
        chk("dis_nwr", 64'(wr_q.size()), 64'd0);
        prog_en = 1'b1;

        words = '{32'd1, 32'd2, 32'd3};
        frame("n3", 32'd3, wsum(), 1'b0);

        words.delete();
        frame("n0", 32'd0, 32'd0, 1'b0);

        gnt_delay = 5;
        rand_words(2);
        frame("stall5", 32'd2, wsum(), 1'b0);
        gnt_delay = TMO + 10;
        rand_words(2);
        frame("stall_long", 32'd2, wsum(), 1'b0);
        gnt_delay = 0;

        words.delete();
        frame("too_big", 32'(MAXW + 1), 32'd0, 1'b0);
        rand_words(MAXW);
        frame("max_n", 32'(MAXW), wsum(), 1'b0);

        // Mid-word stall on the byte stream must trip the timeout, not before.
        gap_max = 0;
        send_word(32'd2);
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (TMO - 2) @(negedge clk);
        chk("tmo_early", 64'(err), 64'd0);
        repeat (4) @(negedge clk);
        chk("tmo_err", 64'({err, done, busy, prog_rst_n}), 64'b1000);
        chk("tmo_nwr", 64'(wr_q.size()), 64'd0);
        wr_q.delete();
        gap_max = 2;
        rand_words(3);
        frame("after_tmo", 32'd3, wsum(), 1'b0);

        rand_words(4);
        frame("en_drop", 32'd4, wsum(), 1'b1);

        if (CK_EN) begin
            words = '{32'd5, 32'd7};
            frame("ck_good", 32'd2, 32'd12, 1'b0);
            frame("ck_bad", 32'd2, 32'd13, 1'b0);
        end

        for (int k = 0; k < 6; k++) begin
            int n;
            n = $urandom_range(1, 8);
            gnt_delay = $urandom_range(0, 3);
            rand_words(n);
            frame("rand", 32'(n), wsum() + 32'(($urandom_range(0, 3) == 0) ? 1 : 0), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
